// File: rtl/meter_pkg.sv
// meter_pkg: shared types and constants for the meter scheduler.
//   state_t          - scheduler FSM states
//   SEL_*            - MeasSel codes (2'b11 is never driven)
//   MODE_*           - leading display digit per meter
//   DP_*             - decimal-point digit index per meter
//   TIMEOUT_SENTINEL - value stored when a meter never answers
package meter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_LATCH,
    ST_HOLD
  } state_t;

  localparam logic [1:0] SEL_FREQ = 2'b00;
  localparam logic [1:0] SEL_PER  = 2'b01;
  localparam logic [1:0] SEL_DUTY = 2'b10;

  localparam logic [3:0] MODE_FREQ = 4'hF;
  localparam logic [3:0] MODE_PER  = 4'hC;
  localparam logic [3:0] MODE_DUTY = 4'hD;

  // kHz and ms both show three decimals, duty shows one
  localparam logic [2:0] DP_FREQ = 3'd3;
  localparam logic [2:0] DP_PER  = 3'd3;
  localparam logic [2:0] DP_DUTY = 3'd1;

  localparam logic [15:0] TIMEOUT_SENTINEL = 16'hFFFF;

  // Round-robin order 00 -> 01 -> 10 -> 00; also used for the display selection.
  function automatic logic [1:0] next_sel(input logic [1:0] sel);
    case (sel)
      SEL_FREQ: next_sel = SEL_PER;
      SEL_PER:  next_sel = SEL_DUTY;
      default:  next_sel = SEL_FREQ;
    endcase
  endfunction

  function automatic logic [3:0] mode_digit(input logic [1:0] sel);
    case (sel)
      SEL_PER:  mode_digit = MODE_PER;
      SEL_DUTY: mode_digit = MODE_DUTY;
      default:  mode_digit = MODE_FREQ;
    endcase
  endfunction

  function automatic logic [2:0] dp_pos(input logic [1:0] sel);
    case (sel)
      SEL_PER:  dp_pos = DP_PER;
      SEL_DUTY: dp_pos = DP_DUTY;
      default:  dp_pos = DP_FREQ;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: two-flop synchronizer plus rising-edge detector for a raw
// asynchronous push-button.
//   clk   - system clock
//   rst_n - asynchronous active-low reset (clears all flops)
//   btn   - raw button level
//   rise  - one-cycle pulse, high in the 2nd cycle after btn is seen high
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/meter_scheduler.sv
// meter_scheduler: cycles frequency / period / duty meters round-robin,
// stores each result and drives an 8-digit display word.
//   Clk, Rst_n          - 100 MHz clock, asynchronous active-low reset
//   En                  - run enable; low returns the FSM to IDLE
//   Button              - raw push-button, steps the displayed result
//   MeasDone, MeasValue - meter reply (value valid while MeasDone is high)
//   MeasStart, MeasSel  - meter request pulse and meter select
//   Number, DpSel       - display word and decimal-point digit index
//   Busy, Timeout       - measurement outstanding, sticky no-answer flag
//   state_dbg           - current FSM state
// Optional feature macro: METER_AUTOSCROLL_EN (periodic display stepping).
//
// Meter handshake: MeasStart is a single-cycle request for the meter named
// by MeasSel; the meter replies with a single-cycle MeasDone and MeasValue is
// valid in that same cycle. A reply is accepted only while Busy is high; a
// reply at any other time is dropped.
module meter_scheduler
  import meter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 200_000_000,
  parameter int unsigned SCROLL_CYCLES  = 300_000_000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        En,
  input  logic        Button,
  input  logic        MeasDone,
  input  logic [15:0] MeasValue,
  output logic        MeasStart,
  output logic [1:0]  MeasSel,
  output logic [31:0] Number,
  output logic [2:0]  DpSel,
  output logic        Busy,
  output logic        Timeout,
  output state_t      state_dbg
);

  state_t      state_q, state_nxt;
  logic [1:0]  sel_q, sel_nxt;
  logic [31:0] cnt_q;
  logic [15:0] result_q [3];
  logic        res_we;
  logic [15:0] res_wdata;
  logic        to_set;
  logic        timeout_q;
  logic [1:0]  disp_q;
  logic        btn_rise;
  logic        disp_step;
  logic [15:0] disp_val;

  // Next-state logic. En low overrides everything, including a reply that
  // arrives in the same cycle.
  always_comb begin
    state_nxt = state_q;
    sel_nxt   = sel_q;
    res_we    = 1'b0;
    res_wdata = MeasValue;
    to_set    = 1'b0;
    if (!En) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_nxt = ST_START;
          sel_nxt   = SEL_FREQ;
        end
        ST_START: state_nxt = ST_WAIT;
        ST_WAIT: begin
          // a reply in the terminal cycle beats the timeout
          if (MeasDone) begin
            res_we    = 1'b1;
            state_nxt = ST_LATCH;
          end else if (cnt_q == TIMEOUT_CYCLES - 1) begin
            res_we    = 1'b1;
            res_wdata = TIMEOUT_SENTINEL;
            to_set    = 1'b1;
            state_nxt = ST_LATCH;
          end
        end
        ST_LATCH: state_nxt = ST_HOLD;
        ST_HOLD: begin
          if (cnt_q == HOLD_CYCLES - 1) begin
            state_nxt = ST_START;
            sel_nxt   = next_sel(sel_q);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // The shared counter only runs in WAIT and HOLD and restarts from zero on
  // every state change, so it never wraps within a state.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= SEL_FREQ;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      sel_q     <= sel_nxt;
      timeout_q <= timeout_q | to_set;
      if ((state_nxt != state_q) || !(state_q inside {ST_WAIT, ST_HOLD}))
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      result_q[0] <= '0;
      result_q[1] <= '0;
      result_q[2] <= '0;
    end else if (res_we) begin
      case (sel_q)
        SEL_PER:  result_q[1] <= res_wdata;
        SEL_DUTY: result_q[2] <= res_wdata;
        default:  result_q[0] <= res_wdata;
      endcase
    end
  end

  btn_sync_edge u_btn (
    .clk   (Clk),
    .rst_n (Rst_n),
    .btn   (Button),
    .rise  (btn_rise)
  );

`ifdef METER_AUTOSCROLL_EN
  logic [31:0] scroll_cnt_q;
  logic        scroll_tick;

  assign scroll_tick = En && (scroll_cnt_q == SCROLL_CYCLES - 1);

  // A button press restarts the scroll period; a coincident tick and press
  // step the display only once.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      scroll_cnt_q <= '0;
    else if (btn_rise || scroll_tick)
      scroll_cnt_q <= '0;
    else if (En)
      scroll_cnt_q <= scroll_cnt_q + 32'd1;
  end

  assign disp_step = btn_rise | scroll_tick;
`else
  assign disp_step = btn_rise;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      disp_q <= SEL_FREQ;
    else if (disp_step)
      disp_q <= next_sel(disp_q);
  end

  always_comb begin
    disp_val = result_q[0];
    case (disp_q)
      SEL_PER:  disp_val = result_q[1];
      SEL_DUTY: disp_val = result_q[2];
      default:  disp_val = result_q[0];
    endcase
  end

  assign Number    = {mode_digit(disp_q), 12'h000, disp_val};
  assign DpSel     = dp_pos(disp_q);
  assign MeasStart = (state_q == ST_START);
  assign Busy      = (state_q == ST_WAIT);
  assign MeasSel   = sel_q;
  assign Timeout   = timeout_q;
  assign state_dbg = state_q;

endmodule
